// File: rtl/regfile_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bus_ctrl
// Description : Bus-side access controller in front of a register file.
//               Accepts one read/write per req, waits WAIT_CYC cycles, then
//               drives the regfile port for one access cycle and acknowledges
//               with a one-cycle ack. Out-of-range addresses complete with err.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bus_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int DATA_D   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rf_we_,
    input  logic [DATA_W-1:0] rf_d_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter reload: WAIT_CYC-1 so that WAIT lasts exactly WAIT_CYC cycles.
    localparam logic [3:0]      c_wait_init = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
    // One extra bit so DATA_D == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] c_data_d    = (ADDR_W + 1)'(DATA_D);
    localparam logic            c_no_wait   = (WAIT_CYC == 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic        w_out_of_range;

    assign w_out_of_range = ({1'b0, addr} >= c_data_d);

    // Busy is the only decoded output; everything else is registered.
    assign busy = (r_state != S_IDLE);

    // Transaction FSM with registered handshake and regfile-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rd_data <= '0;
            rf_addr <= '0;
            rf_d_in <= '0;
            rf_we_  <= 1'b1;
        end else begin
            // ack/err are single-cycle strobes, raised only on entry to DONE.
            ack <= 1'b0;
            err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        rf_addr <= addr;
                        rf_d_in <= wr_data;
                        r_rw    <= rw;
                        r_cnt   <= c_wait_init;
                        if (w_out_of_range) begin
                            // No regfile access: complete immediately with error.
                            r_state <= S_DONE;
                            ack     <= 1'b1;
                            err     <= 1'b1;
                        end else if (c_no_wait) begin
                            r_state <= S_XFER;
                            rf_we_  <= rw;      // write (rw=0) pulls we_ low
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_XFER;
                        rf_we_  <= r_rw;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_XFER: begin
                    // Regfile write commits at this edge; read data captured here.
                    rf_we_ <= 1'b1;
                    if (r_rw) begin
                        rd_data <= rf_d_out;
                    end
                    r_state <= S_DONE;
                    ack     <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bus_ctrl
// Description : Directed self-checking bench for regfile_bus_ctrl. Three
//               instances cover WAIT_CYC=1/DATA_D=6, WAIT_CYC=0 and
//               WAIT_CYC=15, each with its own behavioural register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [1:0]  sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Per-instance signals
    logic        req_a, req_b, req_c;
    logic        ack_a, ack_b, ack_c;
    logic        err_a, err_b, err_c;
    logic        busy_a, busy_b, busy_c;
    logic        we_a, we_b, we_c;
    logic [2:0]  rfa_a, rfa_b, rfa_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic [31:0] din_a, din_b, din_c;
    logic [31:0] dout_a, dout_b, dout_c;

    logic [31:0] rf_a [8];
    logic [31:0] rf_b [8];
    logic [31:0] rf_c [8];

    assign req_a = req && (sel == 2'd0);
    assign req_b = req && (sel == 2'd1);
    assign req_c = req && (sel == 2'd2);

    regfile_bus_ctrl #(.ADDR_W(3), .DATA_W(32), .DATA_D(6), .WAIT_CYC(1)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .rw(rw), .addr(addr), .wr_data(wr_data),
        .ack(ack_a), .err(err_a), .rd_data(rd_a), .busy(busy_a),
        .rf_addr(rfa_a), .rf_d_in(din_a), .rf_we_(we_a), .rf_d_out(dout_a));

    regfile_bus_ctrl #(.ADDR_W(3), .DATA_W(32), .DATA_D(8), .WAIT_CYC(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .rw(rw), .addr(addr), .wr_data(wr_data),
        .ack(ack_b), .err(err_b), .rd_data(rd_b), .busy(busy_b),
        .rf_addr(rfa_b), .rf_d_in(din_b), .rf_we_(we_b), .rf_d_out(dout_b));

    regfile_bus_ctrl #(.ADDR_W(3), .DATA_W(32), .DATA_D(8), .WAIT_CYC(15)) u_c (
        .clk(clk), .reset(reset), .req(req_c), .rw(rw), .addr(addr), .wr_data(wr_data),
        .ack(ack_c), .err(err_c), .rd_data(rd_c), .busy(busy_c),
        .rf_addr(rfa_c), .rf_d_in(din_c), .rf_we_(we_c), .rf_d_out(dout_c));

    // Behavioural register files: combinational read, write on we_=0.
    assign dout_a = rf_a[rfa_a];
    assign dout_b = rf_b[rfa_b];
    assign dout_c = rf_c[rfa_c];

    always @(posedge clk) begin
        if (!we_a) rf_a[rfa_a] <= din_a;
        if (!we_b) rf_b[rfa_b] <= din_b;
        if (!we_c) rf_c[rfa_c] <= din_c;
    end

    // Output view of the currently selected instance
    logic        ack_m, err_m, busy_m, we_m;
    logic [31:0] rd_m;
    logic [2:0]  rfa_m;
    logic [31:0] din_m;
    always_comb begin
        ack_m = ack_a; err_m = err_a; busy_m = busy_a; we_m = we_a;
        rd_m = rd_a; rfa_m = rfa_a; din_m = din_a;
        case (sel)
            2'd1: begin ack_m = ack_b; err_m = err_b; busy_m = busy_b; we_m = we_b;
                        rd_m = rd_b; rfa_m = rfa_b; din_m = din_b; end
            2'd2: begin ack_m = ack_c; err_m = err_c; busy_m = busy_c; we_m = we_c;
                        rd_m = rd_c; rfa_m = rfa_c; din_m = din_c; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue a one-cycle req pulse (entered and left at a negedge) and record
    // the cycle numbers (1 = first cycle after the sampling edge) of events.
    task automatic txn(input logic [1:0] s, input logic r, input logic [2:0] a,
                       input logic [31:0] d, output int ack_cyc, output int we_cyc,
                       output int we_cnt, output int busy_cnt, output logic err_v,
                       output logic [31:0] rd_v);
        sel = s; rw = r; addr = a; wr_data = d; req = 1'b1;
        ack_cyc = -1; we_cyc = -1; we_cnt = 0; busy_cnt = 0; err_v = 1'b0; rd_v = '0;
        @(negedge clk);
        req = 1'b0;
        for (int k = 1; k <= 25 && ack_cyc < 0; k++) begin
            if (!we_m) begin
                we_cnt++;
                if (we_cyc < 0) we_cyc = k;
            end
            if (busy_m) busy_cnt++;
            if (ack_m) begin
                ack_cyc = k;
                err_v   = err_m;
                rd_v    = rd_m;
            end
            @(negedge clk);
        end
    endtask

    int          ac, wc, wn, bc, a1, a2, nack;
    logic        ev, b4;
    logic [31:0] rv;
    logic [2:0]  rfa_hold;

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf_a[i] = '0; rf_b[i] = '0; rf_c[i] = '0;
        end
        sel = 2'd0; req = 1'b0; rw = 1'b0; addr = '0; wr_data = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ack", {31'd0, ack_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_rd", rd_a, 32'd0);
        chk("rst_rfaddr", {29'd0, rfa_a}, 32'd0);
        chk("rst_din", din_a, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 1. Write addr 3
        txn(2'd0, 1'b0, 3'd3, 32'hDEADBEEF, ac, wc, wn, bc, ev, rv);
        chk("t1_ack_cyc", ac, 32'd3);
        chk("t1_we_cyc", wc, 32'd2);
        chk("t1_we_cnt", wn, 32'd1);
        chk("t1_err", {31'd0, ev}, 32'd0);
        chk("t1_busy", bc, 32'd3);
        chk("t1_rd_unchanged", rv, 32'd0);
        chk("t1_rf3", rf_a[3], 32'hDEADBEEF);

        // 2. Read back addr 3
        txn(2'd0, 1'b1, 3'd3, 32'h0, ac, wc, wn, bc, ev, rv);
        chk("t2_ack_cyc", ac, 32'd3);
        chk("t2_we_cnt", wn, 32'd0);
        chk("t2_err", {31'd0, ev}, 32'd0);
        chk("t2_rd", rv, 32'hDEADBEEF);

        // 3. Out-of-range read (DATA_D=6)
        txn(2'd0, 1'b1, 3'd7, 32'h0, ac, wc, wn, bc, ev, rv);
        chk("t3_ack_cyc", ac, 32'd1);
        chk("t3_err", {31'd0, ev}, 32'd1);
        chk("t3_we_cnt", wn, 32'd0);
        chk("t3_rd_hold", rv, 32'hDEADBEEF);
        // Boundary: addr 6 is also out of range, addr 5 is legal
        txn(2'd0, 1'b0, 3'd6, 32'h11111111, ac, wc, wn, bc, ev, rv);
        chk("t3_a6_ack", ac, 32'd1);
        chk("t3_a6_err", {31'd0, ev}, 32'd1);
        txn(2'd0, 1'b0, 3'd5, 32'h55AA55AA, ac, wc, wn, bc, ev, rv);
        chk("t3_a5_ack", ac, 32'd3);
        chk("t3_a5_err", {31'd0, ev}, 32'd0);
        chk("t3_a5_rf", rf_a[5], 32'h55AA55AA);

        // 4. WAIT_CYC=0 and WAIT_CYC=15
        txn(2'd1, 1'b0, 3'd5, 32'h00001234, ac, wc, wn, bc, ev, rv);
        chk("t4_w0_ack", ac, 32'd2);
        chk("t4_w0_we_cyc", wc, 32'd1);
        chk("t4_w0_busy", bc, 32'd2);
        txn(2'd1, 1'b1, 3'd5, 32'h0, ac, wc, wn, bc, ev, rv);
        chk("t4_w0_rd_ack", ac, 32'd2);
        chk("t4_w0_rd", rv, 32'h00001234);
        txn(2'd2, 1'b0, 3'd2, 32'hCAFEF00D, ac, wc, wn, bc, ev, rv);
        chk("t4_w15_ack", ac, 32'd17);
        chk("t4_w15_we_cyc", wc, 32'd16);
        chk("t4_w15_we_cnt", wn, 32'd1);
        chk("t4_w15_busy", bc, 32'd17);
        chk("t4_w15_rf", rf_c[2], 32'hCAFEF00D);

        // 5a. req held high: acks in cycles 3 and 7, IDLE in cycle 4
        sel = 2'd0; rw = 1'b1; addr = 3'd3; req = 1'b1;
        a1 = -1; a2 = -1; b4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) req = 1'b0;
            if (ack_m) begin
                if (a1 < 0) a1 = k;
                else a2 = k;
            end
            if (k == 4) b4 = busy_m;
        end
        chk("t5_ack1", a1, 32'd3);
        chk("t5_ack2", a2, 32'd7);
        chk("t5_idle_gap", {31'd0, b4}, 32'd0);
        repeat (2) @(negedge clk);

        // 5b. req kept high into WAIT with a new addr: ignored, rf_addr stable
        sel = 2'd0; rw = 1'b1; addr = 3'd3; req = 1'b1;
        nack = 0; rfa_hold = 3'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) addr = 3'd5;
            if (k == 2) begin
                req = 1'b0;
                rfa_hold = rfa_m;
            end
            if (ack_m) nack++;
        end
        chk("t5_mid_acks", nack, 32'd1);
        chk("t5_rfaddr_stable", {29'd0, rfa_hold}, 32'd3);

        // 6. Reset during WAIT
        sel = 2'd0; rw = 1'b0; addr = 3'd1; wr_data = 32'h00000055; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", {31'd0, busy_a}, 32'd0);
        chk("t6_ack", {31'd0, ack_a}, 32'd0);
        chk("t6_err", {31'd0, err_a}, 32'd0);
        chk("t6_rd", rd_a, 32'd0);
        chk("t6_rfaddr", {29'd0, rfa_a}, 32'd0);
        chk("t6_din", din_a, 32'd0);
        chk("t6_we", {31'd0, we_a}, 32'd1);
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_a) nack++;
        end
        chk("t6_no_ack", nack, 32'd0);
        chk("t6_no_write", rf_a[1], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
